// File: rtl/ex_complete_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module      : ex_complete_arbiter                                           |
// | Description : Round-robin arbiter sharing the single EX->complete port       |
// |               between NUM_REQ requesters, with a one-entry output stage.     |
// |               Optional macro ARB_STATS_EN adds stall/grant counters.         |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module ex_complete_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int SRC_W   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      squash,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [NUM_REQ*32-1:0]     grant_cnt
`endif
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SRC_W-1:0]  r_out_src;
    logic [SRC_W-1:0]  r_rr_ptr;

    logic              w_slot_free;
    logic              w_grant_ok;
    logic              w_found;
    logic [SRC_W-1:0]  w_win;
    logic [SRC_W-1:0]  w_idx;
    logic              w_grant;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_grant_ok  = w_slot_free && !squash && !reset;

    // Scan from rr_ptr upward; SRC_W-bit addition wraps because NUM_REQ is a power of 2.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = r_rr_ptr + SRC_W'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_grant   = w_grant_ok && w_found;
    assign req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (squash) begin
            r_out_valid <= 1'b0;
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_data  <= req_data[w_win*DATA_W +: DATA_W];
            r_out_src   <= w_win;
            r_rr_ptr    <= w_win + SRC_W'(1);
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

`ifdef ARB_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!squash && r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
        logic [31:0] r_cnt;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (!squash && w_grant && (w_win == SRC_W'(g)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end

        assign grant_cnt[g*32 +: 32] = r_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_complete_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_ex_complete_arbiter                                        |
// | Description : Directed self-checking bench for ex_complete_arbiter.         |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_ex_complete_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int SRC_W   = 2;

    logic                      clock;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      squash;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;
`ifdef ARB_STATS_EN
    logic [31:0]               stall_cnt;
    logic [NUM_REQ*32-1:0]     grant_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    ex_complete_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .SRC_W   (SRC_W)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .squash    (squash),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .grant_cnt (grant_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        squash    = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = 64'h1000 + 64'(i);
        end

        // Reset held two cycles with every requester valid
        repeat (2) begin
            @(negedge clock);
            check("rst_req_ready", 64'(req_ready), 64'h0);
            check("rst_out_valid", 64'(out_valid), 64'h0);
            cyc();
        end
        reset = 1'b0;

        // All requesters valid: grants 0,1,2,3,0 in consecutive cycles
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("rr_req_ready", 64'(req_ready), 64'(1) << (c % 4));
            if (c > 0) begin
                check("rr_out_valid", 64'(out_valid), 64'h1);
                check("rr_out_src", 64'(out_src), 64'((c - 1) % 4));
            end
            cyc();
        end
        req_valid = 4'b0000;
        @(negedge clock);
        check("rr_last_src", 64'(out_src), 64'h0);
        check("rr_last_data", out_data, 64'h1000);
        cyc();

        // Single requester 2 with downstream stalled
        req_data[2*DATA_W +: DATA_W] = 64'hABCD;
        req_valid = 4'b0100;
        @(negedge clock);
        check("single_grant", 64'(req_ready), 64'h4);
        cyc();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("stall_req_ready", 64'(req_ready), 64'h0);
            check("stall_out_valid", 64'(out_valid), 64'h1);
            check("stall_out_data", out_data, 64'hABCD);
            check("stall_out_src", 64'(out_src), 64'h2);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("unstall_grant", 64'(req_ready), 64'h4);
        cyc();
        req_valid = 4'b0000;
        @(negedge clock);
        check("regrant_data", out_data, 64'hABCD);
        cyc();

        // rr_ptr now 3: grant 3, then wrap to 0, pointer ends at 1
        req_valid = 4'b1001;
        @(negedge clock);
        check("wrap_grant3", 64'(req_ready), 64'h8);
        cyc();
        req_valid = 4'b0001;
        @(negedge clock);
        check("wrap_grant0", 64'(req_ready), 64'h1);
        check("wrap_src3", 64'(out_src), 64'h3);
        cyc();
        req_valid = 4'b1111;
        @(negedge clock);
        check("wrap_ptr1", 64'(req_ready), 64'h2);
        check("wrap_src0", 64'(out_src), 64'h0);
        cyc();

        // Squash with a stalled packet buffered
        req_valid = 4'b0010;
        out_ready = 1'b0;
        squash    = 1'b1;
        @(negedge clock);
        check("squash_req_ready", 64'(req_ready), 64'h0);
        check("squash_pre_valid", 64'(out_valid), 64'h1);
        cyc();
        squash = 1'b0;
        @(negedge clock);
        check("squash_killed", 64'(out_valid), 64'h0);
        check("squash_regrant", 64'(req_ready), 64'h2);
        cyc();
        req_valid = 4'b0000;
        @(negedge clock);
        check("squash_after_valid", 64'(out_valid), 64'h1);
        check("squash_after_src", 64'(out_src), 64'h1);
        check("squash_after_data", out_data, 64'h1001);
        cyc();

        // Reset while a packet is buffered
        reset     = 1'b1;
        req_valid = 4'b1111;
        @(negedge clock);
        check("midrst_req_ready", 64'(req_ready), 64'h0);
        cyc();
        reset = 1'b0;
        @(negedge clock);
        check("midrst_out_valid", 64'(out_valid), 64'h0);
        check("midrst_out_data", out_data, 64'h0);
        check("midrst_ptr0", 64'(req_ready), 64'h1);
        cyc();
        reset     = 1'b1;
        req_valid = 4'b0000;
        cyc();
        reset = 1'b0;

`ifdef ARB_STATS_EN
        @(negedge clock);
        check("stats_rst_stall", 64'(stall_cnt), 64'h0);
        check("stats_rst_grant2", 64'(grant_cnt[2*32 +: 32]), 64'h0);
        req_valid = 4'b0100;
        out_ready = 1'b1;
        cyc();
        req_valid = 4'b0000;
        out_ready = 1'b0;
        repeat (5) cyc();
        req_valid = 4'b0100;
        out_ready = 1'b1;
        repeat (2) cyc();
        req_valid = 4'b0000;
        @(negedge clock);
        check("stats_stall", 64'(stall_cnt), 64'h5);
        check("stats_grant0", 64'(grant_cnt[0 +: 32]), 64'h0);
        check("stats_grant1", 64'(grant_cnt[32 +: 32]), 64'h0);
        check("stats_grant2", 64'(grant_cnt[64 +: 32]), 64'h3);
        check("stats_grant3", 64'(grant_cnt[96 +: 32]), 64'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
